odometer_display: RTL and testbench



---
 rtl/odometer_pkg.sv | 45 ++++
 rtl/bcd_decade.sv | 24 ++
 rtl/odometer_display.sv | 110 +++++++++++
 tb/tb_odometer_display.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/odometer_pkg.sv
// Shared constants for the odometer display: 7-segment codes, default timing and the BCD decoder.
package odometer_pkg;

  localparam int unsigned DEF_TICKS_PER_UNIT = 100_000_000;
  localparam int unsigned DEF_SCAN_DIV       = 100_000;
  localparam int unsigned SEG_W              = 8;
  localparam int unsigned BCD_DIGITS         = 6;

  // Segment order {dp,g,f,e,d,c,b,a}, active-high
  localparam logic [SEG_W-1:0] SEG_0     = 8'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 8'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 8'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 8'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 8'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 8'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 8'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 8'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 8'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 8'h6F;
  localparam logic [SEG_W-1:0] SEG_F     = 8'h71;
  localparam logic [SEG_W-1:0] SEG_B     = 8'h7C;
  localparam logic [SEG_W-1:0] SEG_L     = 8'h38;
  localparam logic [SEG_W-1:0] SEG_R     = 8'h50;
  localparam logic [SEG_W-1:0] SEG_DASH  = 8'h40;
  localparam logic [SEG_W-1:0] SEG_BLANK = 8'h00;

  function automatic logic [SEG_W-1:0] bcd_to_seg(input logic [3:0] d);
    logic [SEG_W-1:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bcd_decade.sv
// One BCD decade of the odometer; carry_out is combinational so a full ripple settles within one cycle.
module bcd_decade (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic       carry_out,
  output logic [3:0] q
);

  assign carry_out = inc & (q == 4'd9);

  // Clear wins over a same-cycle increment
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 4'd0;
    end else if (clr) begin
      q <= 4'd0;
    end else if (inc) begin
      q <= carry_out ? 4'd0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/odometer_display.sv
// Odometer: counts movement ticks into a 6-digit BCD mileage and scans it, plus turn/direction glyphs, onto an 8-digit display.
module odometer_display
  import odometer_pkg::*;
#(
  parameter int unsigned TICKS_PER_UNIT = DEF_TICKS_PER_UNIT,
  parameter int unsigned SCAN_DIV       = DEF_SCAN_DIV
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        car_on,
  input  logic        move_fwd,
  input  logic        move_bwd,
  input  logic        turn_l,
  input  logic        turn_r,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_cat,
  output logic [23:0] mileage
);

  localparam int unsigned TICK_W = $clog2(TICKS_PER_UNIT);
  localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICKS_PER_UNIT - 1);
  localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_DIV - 1);

  logic [TICK_W-1:0] r_tick;
  logic [SCAN_W-1:0] r_scan;
  logic [2:0]        r_idx;
  logic [7:0]        r_seg_an;
  logic [7:0]        r_seg_cat;

  logic              w_moving;
  logic              w_scan_wrap;
  logic [BCD_DIGITS:0] w_carry;
  logic [23:0]       w_mileage;
  logic [2:0]        w_next_idx;
  logic [7:0]        w_next_seg;
  logic              w_unused_rollover;

  assign w_moving    = car_on & (move_fwd | move_bwd);
  assign w_carry[0]  = w_moving & (r_tick == TICK_MAX);
  assign w_scan_wrap = (r_scan == SCAN_MAX);
  assign w_unused_rollover = w_carry[BCD_DIGITS];

  // Partial distance is kept across pauses; only power-off clears it
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick <= '0;
    end else if (!car_on) begin
      r_tick <= '0;
    end else if (w_moving) begin
      r_tick <= (r_tick == TICK_MAX) ? '0 : r_tick + TICK_W'(1);
    end
  end

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_dec
    bcd_decade u_dec (
      .sys_clk   (sys_clk),
      .rst_n     (rst_n),
      .clr       (~car_on),
      .inc       (w_carry[g]),
      .carry_out (w_carry[g+1]),
      .q         (w_mileage[4*g +: 4])
    );
  end

  // Glyph for the digit about to be lit on the next scan step
  always_comb begin
    w_next_idx = r_idx + 3'd1;
    w_next_seg = SEG_BLANK;
    case (w_next_idx)
      3'd0: w_next_seg = bcd_to_seg(w_mileage[3:0]);
      3'd1: w_next_seg = bcd_to_seg(w_mileage[7:4]);
      3'd2: w_next_seg = bcd_to_seg(w_mileage[11:8]);
      3'd3: w_next_seg = bcd_to_seg(w_mileage[15:12]);
      3'd4: w_next_seg = bcd_to_seg(w_mileage[19:16]);
      3'd5: w_next_seg = bcd_to_seg(w_mileage[23:20]);
      3'd6: w_next_seg = turn_l ? SEG_L : (turn_r ? SEG_R : SEG_BLANK);
      default: w_next_seg = move_bwd ? SEG_B : (move_fwd ? SEG_F : SEG_DASH);
    endcase
  end

  // Scan keeps running while powered off so the frame phase is never disturbed
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan    <= '0;
      r_idx     <= 3'd0;
      r_seg_an  <= 8'h00;
      r_seg_cat <= 8'h00;
    end else begin
      if (w_scan_wrap) begin
        r_scan <= '0;
        r_idx  <= w_next_idx;
      end else begin
        r_scan <= r_scan + SCAN_W'(1);
      end
      if (!car_on) begin
        r_seg_an  <= 8'h00;
        r_seg_cat <= 8'h00;
      end else if (w_scan_wrap) begin
        r_seg_an  <= 8'(8'd1 << w_next_idx);
        r_seg_cat <= w_next_seg;
      end
    end
  end

  assign seg_an  = r_seg_an;
  assign seg_cat = r_seg_cat;
  assign mileage = w_mileage;

endmodule

// File: tb/tb_odometer_display.sv
// Self-checking bench for odometer_display: decimal/arithmetic reference model, vector table, corner sequences, random run.
module tb_odometer_display;

  localparam int T = 4;
  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        car_on = 1'b0;
  logic        move_fwd = 1'b0;
  logic        move_bwd = 1'b0;
  logic        turn_l = 1'b0;
  logic        turn_r = 1'b0;
  logic [7:0]  seg_an;
  logic [7:0]  seg_cat;
  logic [23:0] mileage;

  int errors = 0;
  int checks = 0;

  // Reference model state: plain integers
  int          m_k;
  int          m_tick;
  int          m_mil;
  logic [7:0]  m_an;
  logic [7:0]  m_cat;

  logic [7:0] seg_dig [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
  int         p10 [6]      = '{1, 10, 100, 1000, 10000, 100000};
  logic [7:0] walk [16]    = '{8'h00, 8'h02, 8'h02, 8'h04, 8'h04, 8'h08, 8'h08, 8'h10,
                               8'h10, 8'h20, 8'h20, 8'h40, 8'h40, 8'h80, 8'h80, 8'h01};

  typedef struct {
    string       name;
    logic        on;
    logic        fwd;
    logic        bwd;
    int          cycles;
    logic [23:0] exp_mil;
  } vec_t;

  vec_t vt [5];

  odometer_display #(.TICKS_PER_UNIT(T), .SCAN_DIV(S)) dut (
    .sys_clk  (clk),
    .rst_n    (rst_n),
    .car_on   (car_on),
    .move_fwd (move_fwd),
    .move_bwd (move_bwd),
    .turn_l   (turn_l),
    .turn_r   (turn_r),
    .seg_an   (seg_an),
    .seg_cat  (seg_cat),
    .mileage  (mileage)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] to_bcd(input int m);
    logic [23:0] b;
    b = '0;
    for (int i = 0; i < 6; i++) b[4*i +: 4] = 4'((m / p10[i]) % 10);
    return b;
  endfunction

  function automatic logic [7:0] m_content(input int idx);
    if (idx < 6) return seg_dig[(m_mil / p10[idx]) % 10];
    if (idx == 6) return turn_l ? 8'h38 : (turn_r ? 8'h50 : 8'h00);
    return move_bwd ? 8'h7C : (move_fwd ? 8'h71 : 8'h40);
  endfunction

  // One rising edge of the specified behaviour, using the inputs held across it
  task automatic model_edge();
    int idx;
    m_k++;
    if (!car_on) begin
      m_an  = 8'h00;
      m_cat = 8'h00;
    end else if (m_k % S == 0) begin
      idx   = (m_k / S) % 8;
      m_an  = 8'(1 << idx);
      m_cat = m_content(idx);
    end
    if (!car_on) begin
      m_tick = 0;
      m_mil  = 0;
    end else if (move_fwd || move_bwd) begin
      m_tick++;
      if (m_tick == T) begin
        m_tick = 0;
        m_mil  = (m_mil + 1) % 1000000;
      end
    end
  endtask

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("mileage", mileage, to_bcd(m_mil));
    check("seg_an", 24'(seg_an), 24'(m_an));
    check("seg_cat", 24'(seg_cat), 24'(m_cat));
  endtask

  // Asynchronous reset away from any clock edge; returns at a negedge with reset released
  task automatic do_reset();
    #2 rst_n = 1'b0;
    m_k = 0; m_tick = 0; m_mil = 0; m_an = 8'h00; m_cat = 8'h00;
    #1;
    check("reset_mileage", mileage, 24'h000000);
    check("reset_seg_an", 24'(seg_an), 24'h0);
    check("reset_seg_cat", 24'(seg_cat), 24'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_in(input logic on, input logic f, input logic b, input logic l, input logic r);
    car_on = on; move_fwd = f; move_bwd = b; turn_l = l; turn_r = r;
  endtask

  // Step until the given digit is lit, then check its glyph
  task automatic wait_digit(input string name, input logic [7:0] an, input logic [7:0] cat);
    bit found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (seg_an == an) found = 1;
    end
    if (found) check(name, 24'(seg_cat), 24'(cat));
    else check({name, "_timeout"}, 24'(seg_an), 24'(an));
  endtask

  initial begin
    vt[0] = '{"idle100",  1'b1, 1'b0, 1'b0, 100, 24'h000000};
    vt[1] = '{"fwd40",    1'b1, 1'b1, 1'b0, 40,  24'h000010};
    vt[2] = '{"fwd6",     1'b1, 1'b1, 1'b0, 6,   24'h000011};
    vt[3] = '{"idle20",   1'b1, 1'b0, 1'b0, 20,  24'h000011};
    vt[4] = '{"bwd2",     1'b1, 1'b0, 1'b1, 2,   24'h000012};

    do_reset();
    foreach (vt[v]) begin
      set_in(vt[v].on, vt[v].fwd, vt[v].bwd, 1'b0, 1'b0);
      for (int c = 0; c < vt[v].cycles; c++) step();
      check(vt[v].name, mileage, vt[v].exp_mil);
    end

    // Direction and turn glyphs
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_digit("dig7_dash", 8'h80, 8'h40);
    wait_digit("dig6_blank", 8'h40, 8'h00);
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_digit("dig7_bwd", 8'h80, 8'h7C);
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_digit("dig7_bwd_prio", 8'h80, 8'h7C);
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_digit("dig7_fwd", 8'h80, 8'h71);
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_digit("dig6_right", 8'h40, 8'h50);

    // Scan walk from reset with both turns requested
    do_reset();
    set_in(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) begin
      step();
      check("scan_walk", 24'(seg_an), 24'(walk[i]));
      if (i == 11 || i == 12) check("dig6_left_prio", 24'(seg_cat), 24'h000038);
    end

    // Rollover 999999 -> 000000
    do_reset();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    m_mil = 999999;
    force dut.g_dec[0].u_dec.q = 4'd9;
    force dut.g_dec[1].u_dec.q = 4'd9;
    force dut.g_dec[2].u_dec.q = 4'd9;
    force dut.g_dec[3].u_dec.q = 4'd9;
    force dut.g_dec[4].u_dec.q = 4'd9;
    force dut.g_dec[5].u_dec.q = 4'd9;
    step();
    release dut.g_dec[0].u_dec.q;
    release dut.g_dec[1].u_dec.q;
    release dut.g_dec[2].u_dec.q;
    release dut.g_dec[3].u_dec.q;
    release dut.g_dec[4].u_dec.q;
    release dut.g_dec[5].u_dec.q;
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step();
    check("pre_wrap", mileage, 24'h999999);
    step();
    check("wrap_to_zero", mileage, 24'h000000);

    // Power-off on the same edge as a unit increment
    do_reset();
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step();
    check("before_drop", mileage, 24'h000001);
    car_on = 1'b0;
    step();
    check("drop_mileage", mileage, 24'h000000);
    check("drop_seg_an", 24'(seg_an), 24'h0);
    car_on = 1'b1;
    step();
    check("resume_from_zero", mileage, 24'h000000);

    // Random run against the model, then a mid-run reset
    for (int seg = 0; seg < 400; seg++) begin
      set_in($urandom_range(0, 39) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      for (int c = 0, n = $urandom_range(1, 12); c < n; c++) step();
    end
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) step();
    do_reset();
    for (int i = 0; i < 20; i++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
